dt_repack: RTL and testbench
============================

// Module: dt_repack
// PURPOSE
//   Reverse-direction companion to the distance-transform engine. Scans the 8-bit-per-pixel
//   result/distance RAM (res port), thresholds every pixel and packs 16 pixels per word
//   into the 16-bit binary-image word memory (sti format).
//   Used to regenerate or verify the binary object image from a distance map.
//   Also reports the peak distance value and the object-pixel count.
// PARAMETERS
//   IMG_PIX  16384  pixels per frame (128x128); must be a multiple of 16
//   THRESH   1      pixel is object (bit=1) when res_di >= THRESH (8-bit unsigned compare)
//   RES_AW   14     res address width; must satisfy 2**RES_AW >= IMG_PIX
//   STI_AW   10     sti address width; must satisfy 2**STI_AW >= IMG_PIX/16
// PORTS
//   clk       in   1       clock, rising edge
//   reset     in   1       asynchronous, active-low reset
//   start     in   1       one-cycle request to begin a frame; sampled only in IDLE
//   res_rd    out  1       res RAM read strobe
//   res_addr  out  RES_AW  res RAM pixel address
//   res_di    in   8       res RAM read data, valid the cycle after the address is presented
//   sti_wr    out  1       word-memory write strobe, one cycle per word
//   sti_addr  out  STI_AW  word address
//   sti_do    out  16      packed word; pixel 16w+j sits in bit 15-j (MSB = leftmost pixel)
//   busy      out  1       high from the cycle after start is accepted until done rises
//   done      out  1       high from frame completion until the next accepted start
//   max_dist  out  8       maximum res_di seen over the frame
//   ones_cnt  out  15      number of pixels packed as 1 (0..16384)
// BEHAVIOUR
//   Reset values: all outputs 0 and FSM in IDLE; sticky status registers cleared.
//   All outputs are registered.
//   FSM states:
//     IDLE   wait for start; start=1 -> RUN. On entry to RUN, clear max_dist, ones_cnt
//            and done, and set busy.
//     RUN    cycle k (k=0..IMG_PIX-1) drives res_rd=1, res_addr=k; one address per cycle, no bubbles.
//            After address IMG_PIX-1 -> DRAIN.
//     DRAIN  res_rd=0, res_addr holds; consume the final pixel and write the final word -> FIN.
//     FIN    busy=0, done=1 -> IDLE. done stays high in IDLE until the next start.
//   Pixel k data is sampled at the end of cycle k+1 (one-cycle read latency).
//     - Shift into the pack register at bit 15-(k%16).
//     - Update max_dist: unsigned max of the current value and res_di.
//     - Increment ones_cnt when res_di >= THRESH.
//   Word w: when pixel 16w+15 is sampled, the following cycle drives sti_wr=1,
//     sti_addr=w, sti_do=packed word.
//     - sti_wr is 0 in every other cycle; sti_do/sti_addr hold their last values.
//     - The pack register restarts from 0 for the next word; no partial words are written.
//   Latency, counting the start-sample edge as cycle 0:
//     - first write in cycle 17;
//     - word w written in cycle 16w+17;
//     - last word (w=1023) in cycle 16385;
//     - done=1 from cycle 16386.
//   No special handling of image border pixels: they pack exactly like interior pixels.
//   Boundary conditions:
//     - start while busy or in FIN: ignored, no restart.
//     - start held high: accepted once per IDLE visit.
//     - THRESH=0: every pixel is 1; words all 16'hFFFF and ones_cnt=IMG_PIX.
//     - res_di=8'hFF: max_dist saturates naturally at 8'hFF.
//     - ones_cnt reaching 16384 needs the full 15 bits; no wrap.
//     - reset asserted mid-frame: outputs drop to reset values immediately (asynchronous).
//       No further sti_wr. A new start is required after release.
// TESTING
//   1 All-zero res map, start -> 1024 writes of 16'h0000 at sti_addr 0..1023, ones_cnt=0,
//     max_dist=0, done first high in cycle 16386.
//   2 res[0]=5, others 0 -> word0=16'h8000, all other words 0, ones_cnt=1, max_dist=5.
//   3 res[15]=1 and res[16]=200 -> word0=16'h0001, word1=16'h8000, ones_cnt=2, max_dist=200.
//   4 THRESH=3 with res[32..47]=2,3,2,3,... -> word2=16'h5555, ones_cnt=8.
//   5 Pulse start again at cycle 100 of a frame -> ignored: exactly 1024 writes, one done.
//   6 Reset at cycle 5000 -> sti_wr stays 0 afterward, all outputs 0;
//     new start -> full correct frame, counts restart from 0.

Source files
------------

// File: rtl/dt_repack.sv
// dt_repack: thresholds an 8-bit distance map and packs 16 pixels per 16-bit word.
// Revision 1.0
`default_nettype none

module dt_repack #(
  parameter int          IMG_PIX = 16384,
  parameter logic [7:0]  THRESH  = 8'd1,
  parameter int          RES_AW  = 14,
  parameter int          STI_AW  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              res_rd,
  output logic [RES_AW-1:0] res_addr,
  input  logic [7:0]        res_di,
  output logic              sti_wr,
  output logic [STI_AW-1:0] sti_addr,
  output logic [15:0]       sti_do,
  output logic              busy,
  output logic              done,
  output logic [7:0]        max_dist,
  output logic [14:0]       ones_cnt
);

  localparam logic [RES_AW-1:0] LAST_ADDR = RES_AW'(IMG_PIX - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t            state;
  logic              pix_vld;
  logic [3:0]        bit_cnt;
  logic [15:0]       pack;
  logic [STI_AW-1:0] word_cnt;
  logic              hit;
  logic [15:0]       next_word;

  assign hit       = (res_di >= THRESH);
  assign next_word = {pack[14:0], hit};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      pix_vld  <= 1'b0;
      bit_cnt  <= 4'd0;
      pack     <= 16'd0;
      word_cnt <= '0;
      res_rd   <= 1'b0;
      res_addr <= '0;
      sti_wr   <= 1'b0;
      sti_addr <= '0;
      sti_do   <= 16'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      max_dist <= 8'd0;
      ones_cnt <= 15'd0;
    end else begin
      sti_wr  <= 1'b0;
      // pix_vld marks the cycle in which res_di carries the pixel addressed one cycle earlier
      pix_vld <= res_rd;

      if (pix_vld) begin
        bit_cnt <= bit_cnt + 4'd1;
        if (res_di > max_dist)
          max_dist <= res_di;
        if (hit)
          ones_cnt <= ones_cnt + 15'd1;
        if (bit_cnt == 4'd15) begin
          sti_wr   <= 1'b1;
          sti_addr <= word_cnt;
          sti_do   <= next_word;
          word_cnt <= word_cnt + 1'b1;
          pack     <= 16'd0;
        end else begin
          pack <= next_word;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            done     <= 1'b0;
            max_dist <= 8'd0;
            ones_cnt <= 15'd0;
            res_rd   <= 1'b1;
            res_addr <= '0;
            bit_cnt  <= 4'd0;
            pack     <= 16'd0;
            word_cnt <= '0;
          end
        end
        RUN: begin
          if (res_addr == LAST_ADDR) begin
            res_rd <= 1'b0;
            state  <= DRAIN;
          end else begin
            res_addr <= res_addr + 1'b1;
          end
        end
        DRAIN: begin
          state <= FIN;
        end
        FIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dt_repack.sv
// Directed bench for dt_repack: two instances (THRESH=1 and THRESH=3) share one res RAM image.
`default_nettype none

module tb_dt_repack;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;

  logic        res_rd, res_rd3;
  logic [13:0] res_addr, res_addr3;
  logic [7:0]  res_di, res_di3;
  logic        sti_wr, sti_wr3;
  logic [9:0]  sti_addr, sti_addr3;
  logic [15:0] sti_do, sti_do3;
  logic        busy, busy3, done, done3;
  logic [7:0]  max_dist, max_dist3;
  logic [14:0] ones_cnt, ones_cnt3;

  logic [7:0]  mem [0:16383];
  logic [15:0] wd  [0:1023];
  logic [9:0]  wa  [0:1023];
  logic [15:0] wd3 [0:1023];

  int cyc = 0;
  int base = 0;
  int wn = 0;
  int wn3 = 0;
  int first_wr = -1;
  int done_cyc = -1;
  int done_rises = 0;
  logic prev_done = 1'b0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (res_rd)  res_di  <= mem[res_addr];
    if (res_rd3) res_di3 <= mem[res_addr3];
  end

  dt_repack #(.IMG_PIX(16384), .THRESH(8'd1), .RES_AW(14), .STI_AW(10)) dut (
    .clk(clk), .reset(reset), .start(start),
    .res_rd(res_rd), .res_addr(res_addr), .res_di(res_di),
    .sti_wr(sti_wr), .sti_addr(sti_addr), .sti_do(sti_do),
    .busy(busy), .done(done), .max_dist(max_dist), .ones_cnt(ones_cnt)
  );

  dt_repack #(.IMG_PIX(16384), .THRESH(8'd3), .RES_AW(14), .STI_AW(10)) dut3 (
    .clk(clk), .reset(reset), .start(start),
    .res_rd(res_rd3), .res_addr(res_addr3), .res_di(res_di3),
    .sti_wr(sti_wr3), .sti_addr(sti_addr3), .sti_do(sti_do3),
    .busy(busy3), .done(done3), .max_dist(max_dist3), .ones_cnt(ones_cnt3)
  );

  // Capture writes and done rising edges away from the active edge.
  always @(negedge clk) begin
    if (sti_wr) begin
      if (wn < 1024) begin
        wa[wn] = sti_addr;
        wd[wn] = sti_do;
      end
      if (wn == 0) first_wr = cyc - base;
      wn = wn + 1;
    end
    if (sti_wr3) begin
      wd3[sti_addr3] = sti_do3;
      wn3 = wn3 + 1;
    end
    if (done && !prev_done) begin
      done_rises = done_rises + 1;
      if (done_cyc < 0) done_cyc = cyc - base;
    end
    prev_done = done;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_capture();
    for (int i = 0; i < 1024; i++) begin
      wd[i] = 16'hxxxx;
      wa[i] = 10'hxxx;
      wd3[i] = 16'hxxxx;
    end
    wn = 0; wn3 = 0; first_wr = -1; done_cyc = -1; done_rises = 0;
  endtask

  task automatic start_frame();
    clear_capture();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 base = cyc;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_cycle(input int n);
    while (cyc < base + n) @(negedge clk);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!(done && done3) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, n >= 20000}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  function automatic int addr_errors();
    int e = 0;
    for (int i = 0; i < 1024; i++) if (wa[i] !== 10'(i)) e++;
    return e;
  endfunction

  function automatic int nonzero_from(input int first);
    int e = 0;
    for (int i = first; i < 1024; i++) if (wd[i] !== 16'h0000) e++;
    return e;
  endfunction

  int wn_at_reset;

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sti_wr", {31'd0, sti_wr}, 32'd0);
    chk("rst_res_rd", {31'd0, res_rd}, 32'd0);
    chk("rst_counts", {9'd0, ones_cnt, max_dist}, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Frame A: all-zero map, stray start at cycle 100 must be ignored.
    start_frame();
    wait_cycle(100);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("A_busy_mid", {31'd0, busy}, 32'd1);
    wait_done("A_timeout");
    chk("A_first_wr_cycle", 32'(first_wr), 32'd17);
    chk("A_done_cycle", 32'(done_cyc), 32'd16386);
    chk("A_write_count", 32'(wn), 32'd1024);
    chk("A_addr_order", 32'(addr_errors()), 32'd0);
    chk("A_nonzero_words", 32'(nonzero_from(0)), 32'd0);
    chk("A_ones_cnt", {17'd0, ones_cnt}, 32'd0);
    chk("A_max_dist", {24'd0, max_dist}, 32'd0);
    chk("A_done_rises", 32'(done_rises), 32'd1);
    chk("A_busy_end", {31'd0, busy}, 32'd0);
    chk("A_done_held", {31'd0, done}, 32'd1);

    // Frame B: isolated pixels plus an alternating 2/3 run in word 2.
    mem[0] = 8'd5;
    mem[15] = 8'd1;
    mem[16] = 8'd200;
    for (int i = 32; i < 48; i++) mem[i] = (i % 2 == 0) ? 8'd2 : 8'd3;
    start_frame();
    chk("B_done_cleared", {31'd0, done}, 32'd0);
    wait_done("B_timeout");
    chk("B_word0", {16'd0, wd[0]}, 32'h8001);
    chk("B_word1", {16'd0, wd[1]}, 32'h8000);
    chk("B_word2", {16'd0, wd[2]}, 32'hFFFF);
    chk("B_rest_zero", 32'(nonzero_from(3)), 32'd0);
    chk("B_ones_cnt", {17'd0, ones_cnt}, 32'd19);
    chk("B_max_dist", {24'd0, max_dist}, 32'd200);
    chk("B3_word0", {16'd0, wd3[0]}, 32'h8000);
    chk("B3_word1", {16'd0, wd3[1]}, 32'h8000);
    chk("B3_word2", {16'd0, wd3[2]}, 32'h5555);
    chk("B3_ones_cnt", {17'd0, ones_cnt3}, 32'd10);
    chk("B3_write_count", 32'(wn3), 32'd1024);

    // Frame C: asynchronous reset at cycle 5000.
    start_frame();
    wait_cycle(5000);
    reset = 1'b0;
    #1;
    wn_at_reset = wn;
    chk("C_rst_busy", {31'd0, busy}, 32'd0);
    chk("C_rst_res_rd", {31'd0, res_rd}, 32'd0);
    chk("C_rst_addr", {18'd0, res_addr}, 32'd0);
    chk("C_rst_sti", {6'd0, sti_addr, sti_do}, 32'd0);
    chk("C_rst_counts", {9'd0, ones_cnt, max_dist}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (50) @(negedge clk);
    chk("C_no_writes", 32'(wn - wn_at_reset), 32'd0);
    chk("C_idle", {30'd0, busy, res_rd}, 32'd0);

    // Frame D: fresh start after reset; last pixel saturates max_dist.
    mem[16383] = 8'hFF;
    start_frame();
    wait_done("D_timeout");
    chk("D_done_cycle", 32'(done_cyc), 32'd16386);
    chk("D_write_count", 32'(wn), 32'd1024);
    chk("D_word0", {16'd0, wd[0]}, 32'h8001);
    chk("D_last_word", {16'd0, wd[1023]}, 32'h0001);
    chk("D_ones_cnt", {17'd0, ones_cnt}, 32'd20);
    chk("D_max_dist", {24'd0, max_dist}, 32'd255);
    chk("D3_ones_cnt", {17'd0, ones_cnt3}, 32'd11);
    chk("D3_max_dist", {24'd0, max_dist3}, 32'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
